audio_sfx_scheduler: RTL and testbench
======================================

Name: audio_sfx_scheduler

Overview:
- Shares the codec DAC channel between NUM_REQ sound-effect requesters, e.g. game events such as bomb, explosion and pickup.
- Each effect is a square-wave tone of programmable half-period and duration, stepped once per DAC sample frame.
- Arbitration is fixed-priority with preemption; index 0 has the highest priority.
- Outputs drive dacdata_left/dacdata_right of the audio codec controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AMPLITUDE, 16'd8192, magnitude of the square wave; the sample is +AMPLITUDE or -AMPLITUDE in two's complement.
- GAP_SAMPLES, 4, number of silent samples inserted after an effect completes normally.

Ports:
- CLOCK31_5  in  1  system clock, the same 31.5 MHz clock as the codec controller.
- reset  in  1  synchronous, active-high reset.
- AUD_DACLRCK  in  1  raw codec DAC LR clock; asynchronous to CLOCK31_5.
- req  in  NUM_REQ  one-cycle request pulses; bit i requests effect i.
- half_period  in  NUM_REQ*12  per-requester tone half-period in samples; requester i uses bits [12i+11:12i].
- duration  in  NUM_REQ*16  per-requester effect length in samples; requester i uses bits [16i+15:16i].
- mute  in  1  forces the audio outputs to 0; sequencing continues.
- dacdata_left  out  16  sample to the codec.
- dacdata_right  out  16  identical to dacdata_left.
- busy  out  1  high whenever state is not IDLE.
- active_id  out  $clog2(NUM_REQ)  index of the effect currently playing.
- done  out  1  one-cycle pulse when an effect completes normally.

Behaviour:
- Sample tick:
  - AUD_DACLRCK passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is a 1-cycle pulse, 3 clock cycles after the raw rising edge.
  - All state changes except pending-set happen only on tick.
- Pending register:
  - pending[i] is set by req[i] in any cycle and cleared when effect i is granted.
  - If req[i] arrives in the same cycle that i is granted, pending[i] stays set, so the effect replays later.
  - Repeated req while pending has no additional effect; requests do not count.
- Grant:
  - The pending index with the lowest number wins.
  - On grant, the block latches hp = half_period[i] (0 is treated as 1) and dur = duration[i].
  - It also sets active_id = i, phase = high, half-period counter = 0.
  - On the grant tick the output is the first sample (+AMPLITUDE) and remaining = dur-1.
  - If dur == 0: no sample is played; the output is 0, done pulses on the next cycle, and the state goes to GAP.
- States:
  - IDLE: output 0. On tick with any pending bit, grant and go to PLAY; otherwise stay in IDLE.
  - PLAY, on each tick, evaluated in this priority order:
    - (1) If a pending index < active_id exists: preempt. The current effect is aborted without being re-queued and without a done pulse. Grant the new index and stay in PLAY.
    - (2) Else if remaining == 0: output 0, pulse done for 1 cycle, load gap_cnt = GAP_SAMPLES, go to GAP.
    - (3) Else: output the next square-wave sample and decrement remaining. The half-period counter increments; when it reaches hp-1 the phase toggles and the counter clears. The phase toggle applies to the sample output on the following tick.
  - GAP: output 0, no preemption.
    - On tick with gap_cnt == 0, behave exactly as IDLE: grant if pending, else go to IDLE.
    - Otherwise decrement gap_cnt.
    - With GAP_SAMPLES = 0, a new effect can start on the first tick after completion.
- Output timing and mute:
  - dacdata_left and dacdata_right are registered, equal, and update only on tick.
  - When mute is high they hold 0, and any change to mute takes effect at the next tick.
- Equal priority: a request for the currently active id never preempts; it waits until completion.
- Reset (synchronous, highest precedence, including in the middle of an effect):
  - State goes to IDLE; pending, counters, phase and active_id are cleared.
  - dacdata_left, dacdata_right, busy and done are 0.
  - A req asserted in the reset cycle is ignored.
  - The synchronizer flops are cleared, so the first tick after reset needs a fresh LRCK rising edge.

Test Plan:
- LRCK period 32 clocks; req[2] pulse with half_period=2, duration=6 -> samples +8192,+8192,-8192,-8192,+8192,+8192, then 0; done pulses once; busy stays high through 4 gap samples, then IDLE.
- req[1] and req[3] in the same cycle -> 1 plays first; after completion plus 4 gap samples, 3 plays; active_id sequence is 1 then 3.
- req[3] playing duration=100; req[0] pulses at its sample 10 -> at the next tick active_id=0 with sample +8192; no done pulse for 3; effect 3 is never replayed.
- req[0] playing; req[2] arrives -> no preemption; 2 starts after effect 0's done pulse plus the gap.
- duration=0 request -> busy high, outputs stay 0, done pulses once, GAP then IDLE; half_period=0 behaves as 1 (alternating +8192/-8192).
- Assert reset mid-PLAY, together with req[1] -> next cycle: outputs 0, busy 0, pending empty; no playback until a new req arrives.
- mute=1 during playback -> outputs 0 from the next tick while done still arrives at the nominal tick.

Source files
------------

// File: rtl/audio_sfx_scheduler.sv
// Fixed-priority, preemptive square-wave sound-effect scheduler driving the codec DAC.
// All sequencing is paced by a tick derived from the codec's LR clock.
module audio_sfx_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [15:0] AMPLITUDE   = 16'd8192,
  parameter int unsigned GAP_SAMPLES = 4
) (
  input  logic                       CLOCK31_5,
  input  logic                       reset,
  input  logic                       AUD_DACLRCK,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*12-1:0]      half_period,
  input  logic [NUM_REQ*16-1:0]      duration,
  input  logic                       mute,
  output logic [15:0]                dacdata_left,
  output logic [15:0]                dacdata_right,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       done
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned GapW   = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;
  localparam logic [15:0] AmpNeg = ~AMPLITUDE + 16'd1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e             state_q, state_d;
  logic               lr_s1_q, lr_s2_q, lr_s3_q, tick_q;
  logic [NUM_REQ-1:0] pending_q, pending_d, grant_oh;
  logic [IdW-1:0]     id_q, id_d, pri_id;
  logic               any_pend, do_grant;
  logic [11:0]        hp_q, hp_d, cnt_q, cnt_d, sel_hp, new_hp;
  logic [15:0]        rem_q, rem_d, sel_dur;
  logic               phase_q, phase_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [15:0]        out_q, out_d, sample;
  logic               done_q, done_d;

  always_ff @(posedge CLOCK31_5) begin
    if (reset) begin
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      lr_s3_q   <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= StIdle;
      pending_q <= '0;
      id_q      <= '0;
      hp_q      <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      phase_q   <= 1'b0;
      gap_q     <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      lr_s1_q   <= AUD_DACLRCK;
      lr_s2_q   <= lr_s1_q;
      lr_s3_q   <= lr_s2_q;
      tick_q    <= lr_s2_q & ~lr_s3_q;
      state_q   <= state_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

  // Lowest pending index wins; its programming is muxed out for a possible grant.
  always_comb begin
    pri_id  = '0;
    sel_hp  = '0;
    sel_dur = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) pri_id = IdW'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pri_id == IdW'(i)) begin
        sel_hp  = half_period[i*12 +: 12];
        sel_dur = duration[i*16 +: 16];
      end
    end
  end

  assign any_pend = |pending_q;
  assign new_hp   = (sel_hp == 12'd0) ? 12'd1 : sel_hp;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    out_d    = out_q;
    done_d   = 1'b0;
    sample   = '0;
    do_grant = 1'b0;
    grant_oh = '0;
    if (tick_q) begin
      case (state_q)
        StIdle: do_grant = any_pend;
        StPlay: begin
          if (any_pend && (pri_id < id_q)) begin
            do_grant = 1'b1;
          end else if (rem_q == 16'd0) begin
            state_d = StGap;
            gap_d   = GapW'(GAP_SAMPLES);
            done_d  = 1'b1;
          end else begin
            sample = phase_q ? AMPLITUDE : AmpNeg;
            rem_d  = rem_q - 16'd1;
            if (cnt_q == hp_q - 12'd1) begin
              phase_d = ~phase_q;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 12'd1;
            end
          end
        end
        StGap: begin
          if (gap_q != '0) gap_d = gap_q - GapW'(1);
          else if (any_pend) do_grant = 1'b1;
          else state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      if (do_grant) begin
        grant_oh[pri_id] = 1'b1;
        id_d             = pri_id;
        hp_d             = new_hp;
        if (sel_dur == 16'd0) begin
          state_d = StGap;
          gap_d   = GapW'(GAP_SAMPLES);
          done_d  = 1'b1;
          rem_d   = '0;
          phase_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = StPlay;
          rem_d   = sel_dur - 16'd1;
          sample  = AMPLITUDE;
          // The grant sample already counts toward the first half-period.
          phase_d = (new_hp != 12'd1);
          cnt_d   = (new_hp == 12'd1) ? 12'd0 : 12'd1;
        end
      end
      out_d = mute ? 16'd0 : sample;
    end
  end

  // A req landing on its own grant cycle re-arms pending so the effect replays.
  assign pending_d = (pending_q & ~grant_oh) | req;

  assign dacdata_left  = out_q;
  assign dacdata_right = out_q;
  assign busy          = (state_q != StIdle);
  assign active_id     = id_q;
  assign done          = done_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Randomised and directed bench for audio_sfx_scheduler, checked every cycle against a
// sample-index based reference model.
module tb_audio_sfx_scheduler;

  localparam int          NR  = 4;
  localparam int          GAP = 4;
  localparam logic [15:0] POS = 16'd8192;
  localparam logic [15:0] NEG = 16'hE000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lrck = 1'b0;
  logic        mute = 1'b0;
  logic [3:0]  req = '0;
  logic [47:0] half_period = '0;
  logic [63:0] duration = '0;
  logic [15:0] dl, dr;
  logic        busy, done;
  logic [1:0]  aid;

  int checks = 0;
  int errors = 0;

  audio_sfx_scheduler #(
    .NUM_REQ    (NR),
    .AMPLITUDE  (16'd8192),
    .GAP_SAMPLES(GAP)
  ) dut (
    .CLOCK31_5    (clk),
    .reset        (reset),
    .AUD_DACLRCK  (lrck),
    .req          (req),
    .half_period  (half_period),
    .duration     (duration),
    .mute         (mute),
    .dacdata_left (dl),
    .dacdata_right(dr),
    .busy         (busy),
    .active_id    (aid),
    .done         (done)
  );

  always #5 clk = ~clk;

  int lr_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      lr_cnt = (lr_cnt + 1) % 32;
      lrck   = (lr_cnt < 16);
    end
  end

  // ---------------- reference model ----------------
  int          m_state;  // 0 idle, 1 play, 2 gap
  int          m_id, m_hp, m_dur, m_k, m_gap;
  bit [3:0]    m_pend;
  bit          h1, h2, h3, h4;
  logic [15:0] m_out;
  bit          m_done, m_tick, cmp_en;

  function automatic logic [15:0] sample_of(int k, int hp);
    return (((k / hp) % 2) == 0) ? POS : NEG;
  endfunction

  task automatic model_step();
    bit          tk, g;
    int          low;
    logic [15:0] v;
    if (reset) begin
      m_state = 0; m_id = 0; m_hp = 1; m_dur = 0; m_k = 0; m_gap = 0;
      m_pend = '0; h1 = 0; h2 = 0; h3 = 0; h4 = 0;
      m_out = '0; m_done = 0; m_tick = 0; cmp_en = 1;
      return;
    end
    tk = h3 && !h4;
    h4 = h3; h3 = h2; h2 = h1; h1 = lrck;
    m_tick = tk;
    m_done = 0;
    if (tk) begin
      g = 0;
      v = '0;
      low = -1;
      for (int i = NR - 1; i >= 0; i--) if (m_pend[i]) low = i;
      case (m_state)
        0: g = (low >= 0);
        1: begin
          if (low >= 0 && low < m_id) g = 1;
          else if (m_k == m_dur) begin m_state = 2; m_gap = GAP; m_done = 1; end
          else begin v = sample_of(m_k, m_hp); m_k++; end
        end
        default: begin
          if (m_gap > 0) m_gap--;
          else if (low >= 0) g = 1;
          else m_state = 0;
        end
      endcase
      if (g) begin
        m_id = low;
        m_pend[low] = 0;
        m_hp = int'(half_period[low*12 +: 12]);
        if (m_hp == 0) m_hp = 1;
        m_dur = int'(duration[low*16 +: 16]);
        if (m_dur == 0) begin
          m_state = 2; m_gap = GAP; m_done = 1;
        end else begin
          m_state = 1; v = POS; m_k = 1;
        end
      end
      m_out = mute ? 16'd0 : v;
    end
    m_pend = m_pend | req;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("dacdata_left", 32'(dl), 32'(m_out));
        chk("dacdata_right", 32'(dr), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("active_id", 32'(aid), 32'(m_id));
      end
    end
  end

  // ---------------- per-tick logs for literal checks ----------------
  bit          log_en = 0;
  logic [15:0] out_log[$];
  logic [15:0] mout_log[$];
  logic [1:0]  id_log[$];
  logic        busy_log[$];
  logic        done_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (log_en && m_tick) begin
        out_log.push_back(dl);
        mout_log.push_back(m_out);
        id_log.push_back(aid);
        busy_log.push_back(busy);
        done_log.push_back(done);
      end
    end
  end

  task automatic start_log();
    out_log.delete(); mout_log.delete(); id_log.delete();
    busy_log.delete(); done_log.delete();
    log_en = 1;
  endtask

  task automatic wait_log(input int n);
    int budget = 0;
    while (out_log.size() < n && budget < 40 * n + 100) begin
      @(negedge clk);
      budget++;
    end
    if (out_log.size() < n) chk("tick_timeout", 32'(out_log.size()), 32'(n));
  endtask

  task automatic lit_out(input string name, input int idx, input logic [15:0] exp);
    if (idx >= out_log.size()) chk({name, "_missing"}, 32'(out_log.size()), 32'(idx + 1));
    else begin
      chk(name, 32'(out_log[idx]), 32'(exp));
      chk({name, "_model"}, 32'(mout_log[idx]), 32'(exp));
    end
  endtask

  task automatic lit_id(input string name, input int idx, input logic [1:0] exp);
    if (idx >= id_log.size()) chk({name, "_missing"}, 32'(id_log.size()), 32'(idx + 1));
    else chk(name, 32'(id_log[idx]), 32'(exp));
  endtask

  task automatic lit_busy(input string name, input int idx, input logic exp);
    if (idx >= busy_log.size()) chk({name, "_missing"}, 32'(busy_log.size()), 32'(idx + 1));
    else chk(name, 32'(busy_log[idx]), 32'(exp));
  endtask

  task automatic lit_done(input string name, input int idx, input logic exp);
    if (idx >= done_log.size()) chk({name, "_missing"}, 32'(done_log.size()), 32'(idx + 1));
    else chk(name, 32'(done_log[idx]), 32'(exp));
  endtask

  function automatic int done_count();
    int n = 0;
    foreach (done_log[i]) n += int'(done_log[i]);
    return n;
  endfunction

  task automatic settle();
    int budget = 0;
    while ((m_state != 0 || m_pend != 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (m_state != 0) chk("settle_timeout", 32'(m_state), 32'd0);
    budget = 0;
    while (!m_tick && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    log_en = 0;
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic prog(input int i, input int hp, input int dur);
    half_period[i*12 +: 12] = 12'(hp);
    duration[i*16 +: 16]    = 16'(dur);
  endtask

  int ri;
  int ones;

  initial begin
    repeat (5) @(negedge clk);
    reset = 0;
    chk("reset_dac", 32'(dl), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_id", 32'(aid), 32'd0);
    settle();

    // Basic tone: hp=2, dur=6, then 4 gap samples.
    prog(2, 2, 6);
    start_log(); pulse(4'b0100); wait_log(12);
    lit_out("t1_s0", 0, POS); lit_out("t1_s1", 1, POS);
    lit_out("t1_s2", 2, NEG); lit_out("t1_s3", 3, NEG);
    lit_out("t1_s4", 4, POS); lit_out("t1_s5", 5, POS);
    lit_out("t1_s6", 6, 16'd0);
    lit_done("t1_done", 6, 1'b1);
    chk("t1_done_count", 32'(done_count()), 32'd1);
    lit_busy("t1_busy_gap", 10, 1'b1);
    lit_busy("t1_busy_idle", 11, 1'b0);
    settle();

    // Simultaneous requests: 1 then 3.
    prog(1, 3, 5); prog(3, 1, 3);
    start_log(); pulse(4'b1010); wait_log(14);
    lit_id("t2_id_first", 0, 2'd1);
    lit_out("t2_s3", 3, NEG);
    lit_done("t2_done1", 5, 1'b1);
    lit_out("t2_gap", 9, 16'd0);
    lit_id("t2_id_second", 10, 2'd3);
    lit_out("t2_second_s0", 10, POS);
    lit_out("t2_second_s1", 11, NEG);
    lit_done("t2_done3", 13, 1'b1);
    settle();

    // Preemption of 3 by 0 at sample 10.
    prog(3, 5, 100); prog(0, 4, 3);
    start_log(); pulse(4'b1000); wait_log(10);
    pulse(4'b0001); wait_log(22);
    lit_out("t3_s9", 9, NEG);
    lit_id("t3_preempt_id", 10, 2'd0);
    lit_out("t3_preempt_s0", 10, POS);
    lit_done("t3_done0", 13, 1'b1);
    chk("t3_done_count", 32'(done_count()), 32'd1);
    lit_busy("t3_idle", 18, 1'b0);
    lit_busy("t3_no_replay", 21, 1'b0);
    settle();

    // Lower priority arriving during 0 waits.
    prog(0, 2, 4); prog(2, 2, 2);
    start_log(); pulse(4'b0001); wait_log(2);
    pulse(4'b0100); wait_log(11);
    lit_id("t4_no_preempt", 3, 2'd0);
    lit_done("t4_done0", 4, 1'b1);
    lit_out("t4_gap", 8, 16'd0);
    lit_id("t4_second", 9, 2'd2);
    lit_out("t4_second_s0", 9, POS);
    settle();

    // Zero duration, then zero half-period.
    prog(1, 7, 0);
    start_log(); pulse(4'b0010); wait_log(6);
    lit_busy("t5_busy", 0, 1'b1);
    lit_done("t5_done", 0, 1'b1);
    lit_out("t5_silent", 0, 16'd0);
    lit_busy("t5_gap", 4, 1'b1);
    lit_busy("t5_idle", 5, 1'b0);
    settle();
    prog(1, 0, 4);
    start_log(); pulse(4'b0010); wait_log(5);
    lit_out("t5_hp0_s0", 0, POS); lit_out("t5_hp0_s1", 1, NEG);
    lit_out("t5_hp0_s2", 2, POS); lit_out("t5_hp0_s3", 3, NEG);
    lit_done("t5_hp0_done", 4, 1'b1);
    settle();

    // Reset mid-play together with a request.
    prog(3, 2, 50); prog(1, 2, 5);
    start_log(); pulse(4'b1000); wait_log(3);
    @(negedge clk); reset = 1; req = 4'b0010;
    @(negedge clk); reset = 0; req = '0;
    chk("t6_dac", 32'(dl), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    start_log();
    repeat (110) @(negedge clk);
    ones = 0;
    foreach (busy_log[i]) ones += int'(busy_log[i]);
    chk("t6_no_play", 32'(ones), 32'd0);
    chk("t6_ticks_seen", 32'(busy_log.size() >= 2), 32'd1);
    settle();

    // Mute during playback.
    prog(2, 2, 6);
    start_log(); pulse(4'b0100); wait_log(2);
    @(negedge clk); mute = 1;
    wait_log(8);
    mute = 0;
    lit_out("t7_pre_mute", 1, POS);
    lit_out("t7_muted", 2, 16'd0);
    lit_out("t7_muted_late", 5, 16'd0);
    lit_busy("t7_busy", 5, 1'b1);
    lit_done("t7_done", 6, 1'b1);
    settle();

    // Random traffic.
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      req = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 49) == 0) begin
        ri = $urandom_range(0, NR - 1);
        prog(ri, $urandom_range(0, 4), $urandom_range(0, 12));
      end
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      reset = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clk);
    req = '0; reset = 0; mute = 0;
    repeat (50) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
